// File: rtl/regfile_wen_decoder_pipe.sv
// Purpose: decode register write requests into one-hot write enables, buffered in a 2-entry FIFO.
// Latency: 1 cycle from accept to out_valid when empty; otherwise in order behind older entries.
// Backpressure: in_ready drops only when both entries are full (registered count, no out_ready path).
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready      request handshake, in_addr = destination register
//   out_valid/out_ready    decoded-entry handshake, out_wen one-hot, out_addr binary
//   zero_drop, drop_cnt    pulse and saturating count of discarded register-0 writes
module regfile_wen_decoder_pipe #(
  parameter int ADDR_W    = 5,
  parameter int ZERO_LOCK = 1,
  parameter int CNT_W     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_W-1:0]    in_addr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2**ADDR_W-1:0] out_wen,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 zero_drop,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int NREG = 2**ADDR_W;

  logic [ADDR_W-1:0] addr_q [2];
  logic [ADDR_W-1:0] addr_d [2];
  logic [NREG-1:0]   wen_q  [2];
  logic [NREG-1:0]   wen_d  [2];
  logic [1:0]        cnt_q, cnt_d;
  logic              wptr_q, wptr_d;
  logic              rptr_q, rptr_d;
  logic              zero_drop_q, zero_drop_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic              accept;
  logic              is_zero;
  logic              push;
  logic              pop;
  logic [NREG-1:0]   decoded;

  // Both handshake outputs depend only on the registered occupancy.
  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);

  // Stale head contents are masked so nothing leaks while the buffer is empty.
  assign out_wen   = out_valid ? wen_q[rptr_q]  : '0;
  assign out_addr  = out_valid ? addr_q[rptr_q] : '0;
  assign zero_drop = zero_drop_q;
  assign drop_cnt  = drop_cnt_q;

  always_comb begin
    accept  = in_valid & in_ready;
    is_zero = (ZERO_LOCK != 0) && (in_addr == '0);
    // A locked register-0 write completes the handshake but never enters the buffer.
    push    = accept & ~is_zero;
    pop     = out_valid & out_ready;

    decoded          = '0;
    decoded[in_addr] = 1'b1;

    addr_d      = addr_q;
    wen_d       = wen_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    zero_drop_d = accept & is_zero;
    drop_cnt_d  = drop_cnt_q;

    if (push) begin
      addr_d[wptr_q] = in_addr;
      wen_d[wptr_q]  = decoded;
      wptr_d         = ~wptr_q;
    end
    if (pop) begin
      rptr_d = ~rptr_q;
    end

    // With one entry, push+pop writes the free slot and retires the head,
    // so the new entry becomes the head and occupancy holds.
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    if (zero_drop_d && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= '0;
        wen_q[i]  <= '0;
      end
      cnt_q       <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      zero_drop_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      cnt_q       <= cnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      zero_drop_q <= zero_drop_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_regfile_wen_decoder_pipe.sv
// Bench for regfile_wen_decoder_pipe: two instances share stimulus.
// u_lock: ZERO_LOCK=1, CNT_W=2 (register-0 writes discarded, counter saturates at 3).
// u_open: ZERO_LOCK=0, CNT_W=8 (register 0 behaves like any other register).
module tb_regfile_wen_decoder_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [4:0]  in_addr;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, zero_drop_a;
  logic [31:0] out_wen_a;
  logic [4:0]  out_addr_a;
  logic [1:0]  drop_cnt_a;

  logic        in_ready_b, out_valid_b, zero_drop_b;
  logic [31:0] out_wen_b;
  logic [4:0]  out_addr_b;
  logic [7:0]  drop_cnt_b;

  int          errors = 0;
  int          checks = 0;
  int          qa[$];
  int          qb[$];
  logic        zd_exp;
  logic [1:0]  dc_exp;
  int          pops_b;
  int          pops_start;

  always #5 clock = ~clock;

  regfile_wen_decoder_pipe #(.ADDR_W(5), .ZERO_LOCK(1), .CNT_W(2)) u_lock (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_addr(in_addr),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_wen(out_wen_a), .out_addr(out_addr_a),
    .zero_drop(zero_drop_a), .drop_cnt(drop_cnt_a)
  );

  regfile_wen_decoder_pipe #(.ADDR_W(5), .ZERO_LOCK(0), .CNT_W(8)) u_open (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_addr(in_addr),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_wen(out_wen_b), .out_addr(out_addr_b),
    .zero_drop(zero_drop_b), .drop_cnt(drop_cnt_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare one instance against its scoreboard, then update the scoreboard
  // with this cycle's pop and accept.
  task automatic side(input int d, input logic rdy, input logic vld,
                      input logic [31:0] wen, input logic [4:0] ad);
    int sz;
    int e;
    sz = (d == 0) ? qa.size() : qb.size();
    chk($sformatf("in_ready[%0d]", d), 64'(rdy), 64'(sz != 2));
    chk($sformatf("out_valid[%0d]", d), 64'(vld), 64'(sz != 0));
    if (!vld) begin
      chk($sformatf("wen_idle[%0d]", d), 64'(wen), 64'd0);
    end else if (sz != 0) begin
      e = (d == 0) ? qa[0] : qb[0];
      chk($sformatf("out_addr[%0d]", d), 64'(ad), 64'(e));
      chk($sformatf("out_wen[%0d]", d), 64'(wen), 64'(32'd1 << e));
      if (out_ready) begin
        if (d == 0) void'(qa.pop_front());
        else begin
          void'(qb.pop_front());
          pops_b++;
        end
      end
    end
    if (in_valid && rdy) begin
      if (d == 1) qb.push_back(int'(in_addr));
      else if (in_addr != 5'd0) qa.push_back(int'(in_addr));
    end
  endtask

  // Called at a falling edge with inputs already set; advances one clock.
  task automatic step();
    chk("zero_drop[0]", 64'(zero_drop_a), 64'(zd_exp));
    chk("drop_cnt[0]", 64'(drop_cnt_a), 64'(dc_exp));
    chk("zero_drop[1]", 64'(zero_drop_b), 64'd0);
    chk("drop_cnt[1]", 64'(drop_cnt_b), 64'd0);
    side(0, in_ready_a, out_valid_a, out_wen_a, out_addr_a);
    side(1, in_ready_b, out_valid_b, out_wen_b, out_addr_b);
    zd_exp = in_valid && in_ready_a && (in_addr == 5'd0);
    if (zd_exp && dc_exp != 2'd3) dc_exp = dc_exp + 2'd1;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready0"},  64'(in_ready_a),  64'd1);
    chk({tag, "_out_valid0"}, 64'(out_valid_a), 64'd0);
    chk({tag, "_out_wen0"},   64'(out_wen_a),   64'd0);
    chk({tag, "_out_addr0"},  64'(out_addr_a),  64'd0);
    chk({tag, "_zero_drop0"}, 64'(zero_drop_a), 64'd0);
    chk({tag, "_drop_cnt0"},  64'(drop_cnt_a),  64'd0);
    chk({tag, "_in_ready1"},  64'(in_ready_b),  64'd1);
    chk({tag, "_out_valid1"}, 64'(out_valid_b), 64'd0);
    chk({tag, "_out_wen1"},   64'(out_wen_b),   64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_addr   = 5'd0;
    out_ready = 1'b0;
    zd_exp    = 1'b0;
    dc_exp    = 2'd0;
    pops_b    = 0;
    @(negedge clock);
    check_reset_outputs("reset_init");
    reset = 1'b0;
    step();

    // Single write to register 5, consumed immediately.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_addr   = 5'd5;
    step();
    in_valid = 1'b0;
    chk("single_wen", 64'(out_wen_a), 64'h20);
    chk("single_addr", 64'(out_addr_a), 64'd5);
    step();
    chk("single_drained", 64'(out_valid_a), 64'd0);
    step();

    // Fill under back-pressure; the third request is held until space frees.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_addr   = 5'd3;
    step();
    in_addr = 5'd17;
    step();
    in_addr = 5'd9;
    step();
    chk("full_hold", 64'(in_ready_a), 64'd0);
    step();
    out_ready = 1'b1;
    chk("full_head_wen", 64'(out_wen_a), 64'h8);
    step();
    chk("second_wen", 64'(out_wen_a), 64'h0002_0000);
    step();
    in_valid = 1'b0;
    chk("third_wen", 64'(out_wen_a), 64'h200);
    step();
    step();

    // Register-0 writes: discarded by u_lock, delivered by u_open.
    in_valid = 1'b1;
    in_addr  = 5'd0;
    step();
    in_valid = 1'b0;
    chk("zero_pulse", 64'(zero_drop_a), 64'd1);
    chk("zero_open_wen", 64'(out_wen_b), 64'h1);
    step();
    chk("zero_cnt1", 64'(drop_cnt_a), 64'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    in_valid = 1'b0;
    step();
    chk("zero_sat", 64'(drop_cnt_a), 64'd3);
    step();

    // Back-to-back sweep of every address.
    pops_start = pops_b;
    in_valid   = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_addr = 5'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("sweep_throughput", 64'(pops_b - pops_start), 64'd32);
    step();

    // Reset asserted mid-cycle with both entries buffered and a request pending.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_addr   = 5'd3;
    step();
    in_addr = 5'd17;
    step();
    in_addr = 5'd7;
    chk("pre_reset_full", 64'(out_valid_a), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    qa.delete();
    qb.delete();
    zd_exp = 1'b0;
    dc_exp = 2'd0;
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
